// File: rtl/ms_timer.sv
// ms_timer: prescaled up/down counter with run/pause/expire control.
//   CLK, RST_N          : clock (rising edge) and async active-low reset
//   START/STOP/CLR/LOAD : run, pause, clear-to-idle and load controls
//   LOAD_VAL, TERM      : load value and terminal value
//   DIR, ONESHOT        : run mode, latched on START from IDLE/EXPIRED
//   LAP                 : capture COUNT into LAP_COUNT
//   COUNT, LAP_COUNT    : current and captured count (registered)
//   TICK, DONE          : one-cycle pulses on count update / terminal event
//   RUNNING             : combinational decode of the RUN state
module ms_timer #(
  parameter int unsigned CLK_HZ    = 100000000,
  parameter int unsigned TICK_HZ   = 1000,
  parameter int unsigned CNT_WIDTH = 17
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 START,
  input  logic                 STOP,
  input  logic                 CLR,
  input  logic                 LOAD,
  input  logic [CNT_WIDTH-1:0] LOAD_VAL,
  input  logic [CNT_WIDTH-1:0] TERM,
  input  logic                 DIR,
  input  logic                 ONESHOT,
  input  logic                 LAP,
  output logic [CNT_WIDTH-1:0] COUNT,
  output logic [CNT_WIDTH-1:0] LAP_COUNT,
  output logic                 TICK,
  output logic                 DONE,
  output logic                 RUNNING
);

  localparam int unsigned DIV  = CLK_HZ / TICK_HZ;
  localparam int unsigned PS_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_PAUSE   = 2'd2,
    S_EXPIRED = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic [CNT_WIDTH-1:0] lap_q, lap_d;
  logic [PS_W-1:0]      ps_q, ps_d;
  logic                 tick_q, tick_d;
  logic                 done_q, done_d;
  logic                 down_q, down_d;
  logic                 oneshot_q, oneshot_d;

  logic                 tick_edge;
  logic                 at_term;

  // Terminal test uses the latched direction and the live TERM input
  assign tick_edge = (state_q == S_RUN) && (ps_q == PS_LAST);
  assign at_term   = down_q ? (count_q == '0) : (count_q == TERM);

  // Next-state: one prioritised action per edge; LAP capture is independent
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    ps_d      = ps_q;
    down_d    = down_q;
    oneshot_d = oneshot_q;
    tick_d    = 1'b0;
    done_d    = 1'b0;
    lap_d     = LAP ? count_q : lap_q;

    if (CLR) begin
      state_d = S_IDLE;
      count_d = '0;
      ps_d    = '0;
    end else if (LOAD) begin
      count_d = LOAD_VAL;
      ps_d    = '0;
    end else if (STOP && (state_q == S_RUN)) begin
      state_d = S_PAUSE;
    end else if (START && (state_q != S_RUN)) begin
      state_d = S_RUN;
      // Resume from PAUSE keeps count and prescaler; fresh start reloads both
      if (state_q != S_PAUSE) begin
        down_d    = DIR;
        oneshot_d = ONESHOT;
        count_d   = DIR ? TERM : '0;
        ps_d      = '0;
      end
    end else if (state_q == S_RUN) begin
      if (tick_edge) begin
        ps_d   = '0;
        tick_d = 1'b1;
        if (at_term) begin
          done_d = 1'b1;
          if (oneshot_q) begin
            state_d = S_EXPIRED;
          end else begin
            count_d = down_q ? TERM : '0;
          end
        end else begin
          count_d = down_q ? (count_q - CNT_WIDTH'(1)) : (count_q + CNT_WIDTH'(1));
        end
      end else begin
        ps_d = ps_q + PS_W'(1);
      end
    end
  end

  // State and output registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= S_IDLE;
      count_q   <= '0;
      lap_q     <= '0;
      ps_q      <= '0;
      tick_q    <= 1'b0;
      done_q    <= 1'b0;
      down_q    <= 1'b0;
      oneshot_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      lap_q     <= lap_d;
      ps_q      <= ps_d;
      tick_q    <= tick_d;
      done_q    <= done_d;
      down_q    <= down_d;
      oneshot_q <= oneshot_d;
    end
  end

  assign COUNT     = count_q;
  assign LAP_COUNT = lap_q;
  assign TICK      = tick_q;
  assign DONE      = done_q;
  assign RUNNING   = (state_q == S_RUN);

endmodule

// File: tb/tb_ms_timer.sv
// tb_ms_timer: directed scenarios plus randomized control traffic for
// ms_timer (DIV = 10, 4-bit counter, TERM = 5), checked every cycle against
// a behavioural model that tracks elapsed run time per tick period.
module tb_ms_timer;

  localparam int CW  = 4;
  localparam int DIV = 10;
  localparam int MOD = 1 << CW;

  localparam int M_IDLE    = 0;
  localparam int M_RUN     = 1;
  localparam int M_PAUSE   = 2;
  localparam int M_EXPIRED = 3;

  logic          clk;
  logic          rst_n;
  logic          start, stop, clr, load, lap, dir, oneshot;
  logic [CW-1:0] load_val, term;
  logic [CW-1:0] count, lap_count;
  logic          tick, done, running;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model
  int m_state, m_count, m_lap, m_elapsed, m_tick, m_done;
  bit m_down, m_oneshot;

  ms_timer #(
    .CLK_HZ   (10),
    .TICK_HZ  (1),
    .CNT_WIDTH(CW)
  ) dut (
    .CLK      (clk),
    .RST_N    (rst_n),
    .START    (start),
    .STOP     (stop),
    .CLR      (clr),
    .LOAD     (load),
    .LOAD_VAL (load_val),
    .TERM     (term),
    .DIR      (dir),
    .ONESHOT  (oneshot),
    .LAP      (lap),
    .COUNT    (count),
    .LAP_COUNT(lap_count),
    .TICK     (tick),
    .DONE     (done),
    .RUNNING  (running)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0d, expected %0d", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    m_state   = M_IDLE;
    m_count   = 0;
    m_lap     = 0;
    m_elapsed = 0;
    m_tick    = 0;
    m_done    = 0;
    m_down    = 1'b0;
    m_oneshot = 1'b0;
  endtask

  // One clock edge of the specified behaviour, from the current bench inputs
  task automatic model_step();
    int t;
    t = int'(term);
    if (lap) m_lap = m_count;
    m_tick = 0;
    m_done = 0;
    if (clr) begin
      m_state = M_IDLE; m_count = 0; m_elapsed = 0;
    end else if (load) begin
      m_count = int'(load_val); m_elapsed = 0;
    end else if (stop && m_state == M_RUN) begin
      m_state = M_PAUSE;
    end else if (start && m_state != M_RUN) begin
      if (m_state != M_PAUSE) begin
        m_down    = dir;
        m_oneshot = oneshot;
        m_count   = dir ? t : 0;
        m_elapsed = 0;
      end
      m_state = M_RUN;
    end else if (m_state == M_RUN) begin
      m_elapsed++;
      if (m_elapsed == DIV) begin
        m_elapsed = 0;
        m_tick    = 1;
        if ((!m_down && m_count == t) || (m_down && m_count == 0)) begin
          m_done = 1;
          if (m_oneshot) m_state = M_EXPIRED;
          else           m_count = m_down ? t : 0;
        end else begin
          m_count = m_down ? (m_count + MOD - 1) % MOD : (m_count + 1) % MOD;
        end
      end
    end
  endtask

  task automatic compare_all();
    check("count",     32'(count),     32'(m_count));
    check("lap_count", 32'(lap_count), 32'(m_lap));
    check("tick",      32'(tick),      32'(m_tick));
    check("done",      32'(done),      32'(m_done));
    check("running",   32'(running),   32'(m_state == M_RUN));
  endtask

  // Inputs are stable from the previous falling edge; outputs sampled at the next one
  task automatic run_cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle_inputs();
    start = 0; stop = 0; clr = 0; load = 0; lap = 0;
  endtask

  // Mid-cycle reset pulse; outputs must clear before the next rising edge
  task automatic reset_pulse(input string tag);
    rst_n = 1'b0;
    #1;
    model_reset();
    check({tag, "_count"},   32'(count),     0);
    check({tag, "_lap"},     32'(lap_count), 0);
    check({tag, "_tick"},    32'(tick),      0);
    check({tag, "_done"},    32'(done),      0);
    check({tag, "_running"}, 32'(running),   0);
    #1;
    rst_n = 1'b1;
  endtask

  int  ticks_seen, dones_seen, n;
  bit  found;

  initial begin
    rst_n = 1'b1;
    idle_inputs();
    dir = 0; oneshot = 0; load_val = '0; term = 4'd5;
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(negedge clk);
    rst_n = 1'b1;

    // Up, periodic: six ticks in 60 cycles, one DONE at the 5->0 wrap
    dir = 0; oneshot = 0; start = 1;
    run_cycle();
    start = 0;
    ticks_seen = 0; dones_seen = 0;
    for (int i = 0; i < 60; i++) begin
      run_cycle();
      ticks_seen += int'(tick);
      dones_seen += int'(done);
    end
    check("up_ticks", 32'(ticks_seen), 6);
    check("up_dones", 32'(dones_seen), 1);
    check("up_count", 32'(count), 0);
    clr = 1; run_cycle(); clr = 0;

    // Down, oneshot: loads TERM, counts to 0, then expires holding 0
    dir = 1; oneshot = 1; start = 1;
    run_cycle();
    start = 0; dir = 0; oneshot = 0;
    check("down_start", 32'(count), 5);
    dones_seen = 0;
    for (int i = 0; i < 80; i++) begin
      run_cycle();
      dones_seen += int'(done);
    end
    check("down_dones",   32'(dones_seen), 1);
    check("down_count",   32'(count), 0);
    check("down_running", 32'(running), 0);
    clr = 1; run_cycle(); clr = 0;

    // Pause and resume
    start = 1; run_cycle(); start = 0;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      run_cycle();
      if (count == 4'd2) found = 1;
    end
    check("pause_reach2", 32'(found), 1);
    for (int i = 0; i < 4; i++) run_cycle();
    stop = 1; run_cycle(); stop = 0;
    for (int i = 0; i < 20; i++) run_cycle();
    check("pause_hold", 32'(count), 2);
    start = 1; run_cycle(); start = 0;
    n = 0; found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      run_cycle();
      n++;
      if (count == 4'd3) found = 1;
    end
    check("resume_latency", 32'(n), 6);

    // LOAD beats STOP and the tick on the same edge, then wraps past 15
    for (int i = 0; i < 9; i++) run_cycle();
    load = 1; load_val = 4'd9; stop = 1;
    run_cycle();
    load = 0; stop = 0;
    check("prio_count",   32'(count), 9);
    check("prio_tick",    32'(tick), 0);
    check("prio_running", 32'(running), 1);
    dones_seen = 0;
    for (int i = 0; i < 130; i++) begin
      run_cycle();
      dones_seen += int'(done);
    end
    check("wrap_dones", 32'(dones_seen), 1);
    check("wrap_count", 32'(count), 0);

    // LAP on the 3->4 tick edge captures 3
    found = 0;
    for (int i = 0; i < 50 && !found; i++) begin
      run_cycle();
      if (count == 4'd3) found = 1;
    end
    check("lap_reach3", 32'(found), 1);
    for (int i = 0; i < 9; i++) run_cycle();
    lap = 1; run_cycle(); lap = 0;
    check("lap_value", 32'(lap_count), 3);
    check("lap_count4", 32'(count), 4);

    // Reset mid-run aborts; nothing happens until START
    reset_pulse("rst_run");
    ticks_seen = 0;
    for (int i = 0; i < 30; i++) begin
      run_cycle();
      ticks_seen += int'(tick);
    end
    check("rst_no_ticks", 32'(ticks_seen), 0);

    // Randomized control traffic
    for (int i = 0; i < 4000; i++) begin
      start    = ($urandom_range(0, 99) < 6);
      stop     = ($urandom_range(0, 99) < 3);
      clr      = ($urandom_range(0, 199) == 0);
      load     = ($urandom_range(0, 99) < 2);
      lap      = ($urandom_range(0, 99) < 10);
      dir      = 1'($urandom);
      oneshot  = ($urandom_range(0, 3) == 0);
      load_val = CW'($urandom);
      run_cycle();
      if ($urandom_range(0, 499) == 0) reset_pulse("rst_rand");
    end
    idle_inputs();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ms_timer.md
MS_TIMER -- requirements
Module: ms_timer

Interface
REQ-001 The block SHALL take parameter CLK_HZ, default 100000000, meaning the input clock frequency in Hz.
REQ-002 The block SHALL take parameter TICK_HZ, default 1000, meaning the count rate in Hz; DIV = CLK_HZ/TICK_HZ SHALL be at least 1.
REQ-003 The block SHALL take parameter CNT_WIDTH, default 17, meaning the counter width in bits.
REQ-004 Ports SHALL be one per line as follows.
- CLK  in  1  sole clock, rising edge.
- RST_N  in  1  reset, asynchronous, active-low.
- START  in  1  run request, level-sampled.
- STOP  in  1  pause request.
- CLR  in  1  synchronous clear to IDLE.
- LOAD  in  1  load COUNT from LOAD_VAL.
- LOAD_VAL  in  CNT_WIDTH  load value.
- TERM  in  CNT_WIDTH  terminal value.
- DIR  in  1  0 = count up, 1 = count down.
- ONESHOT  in  1  1 = stop at terminal, 0 = periodic.
- LAP  in  1  capture request.
- COUNT  out  CNT_WIDTH  current count.
- LAP_COUNT  out  CNT_WIDTH  captured count.
- TICK  out  1  one-cycle pulse on each count update.
- DONE  out  1  one-cycle pulse on each terminal event.
- RUNNING  out  1  high while in RUN.

Function
REQ-005 The FSM SHALL have exactly four states: IDLE, RUN, PAUSE, EXPIRED.
REQ-006 Control priority SHALL be CLR > LOAD > STOP > START > tick, with one action per edge.
REQ-007 CLR SHALL set COUNT = 0, clear the prescaler and go to IDLE from any state; LAP_COUNT SHALL be unchanged.
REQ-008 LOAD SHALL set COUNT = LOAD_VAL and clear the prescaler in any state, with the state unchanged.
REQ-009 START in IDLE or EXPIRED SHALL do the following.
- Latch DIR and ONESHOT into a run mode.
- Load COUNT with the start value: 0 if up, TERM if down.
- Clear the prescaler and enter RUN.
REQ-010 START in PAUSE SHALL enter RUN with COUNT and the prescaler held, i.e. a resume.
REQ-011 START in RUN SHALL have no effect.
REQ-012 STOP in RUN SHALL enter PAUSE and freeze COUNT and the prescaler; STOP in any other state SHALL have no effect.
REQ-013 The prescaler SHALL advance only in RUN, counting 0..DIV-1; the tick SHALL occur on the edge where the prescaler equals DIV-1, and the prescaler SHALL then return to 0.
REQ-014 The first count update SHALL occur DIV edges after the edge that sampled START from IDLE or EXPIRED.
REQ-015 On a tick with the latched mode up:
- If COUNT == TERM: COUNT SHALL become 0 when periodic, or stay at TERM and the state SHALL go to EXPIRED when oneshot.
- Otherwise COUNT SHALL become COUNT+1 modulo 2^CNT_WIDTH.
REQ-016 On a tick with the latched mode down:
- If COUNT == 0: COUNT SHALL become TERM when periodic, or stay at 0 and the state SHALL go to EXPIRED when oneshot.
- Otherwise COUNT SHALL become COUNT-1.
REQ-017 Terminal detection SHALL use equality only; an up-count loaded above TERM SHALL wrap through 2^CNT_WIDTH-1 to 0 and continue toward TERM.
REQ-018 TICK SHALL be registered and asserted for exactly the cycle following each tick edge, aligned with the updated COUNT.
REQ-019 DONE SHALL be registered and asserted for exactly the cycle following each terminal tick edge, in both periodic and oneshot modes.
REQ-020 LAP SHALL capture the pre-edge COUNT into LAP_COUNT in any state, with one-cycle latency; LAP coincident with a tick SHALL capture the pre-increment value.
REQ-021 A change to TERM during RUN SHALL take effect at the next tick comparison; a change to DIR or ONESHOT SHALL be ignored until the next START from IDLE or EXPIRED.
REQ-022 RUNNING SHALL be the combinational decode of state == RUN.

Reset
REQ-023 Assertion of RST_N low SHALL immediately and asynchronously set the following, regardless of CLK:
- state = IDLE, COUNT = 0, LAP_COUNT = 0, prescaler = 0.
- TICK = 0, DONE = 0, RUNNING = 0.
- Latched mode = up, periodic.
REQ-024 Reset asserted mid-run SHALL abort the run; after deassertion the block SHALL remain in IDLE until START.

Verification
Benches SHALL use CLK_HZ = 10, TICK_HZ = 1 (DIV = 10), CNT_WIDTH = 4 and TERM = 5.
REQ-025 Up, periodic: START, then run 60 cycles -> TICK every 10 cycles; COUNT follows 1,2,3,4,5,0; DONE pulses once with COUNT = 0.
REQ-026 Down, oneshot: START -> COUNT = 5 immediately, then 4,3,2,1,0; DONE pulses once; state goes to EXPIRED; COUNT holds 0 thereafter; RUNNING = 0.
REQ-027 Pause and resume: STOP 4 cycles after the COUNT = 2 update, hold 20 cycles, then START -> next update to 3 arrives 6 cycles after the resume edge.
REQ-028 Priority: LOAD(LOAD_VAL = 9) together with STOP and a tick edge -> COUNT = 9, state unchanged, no TICK; then up periodic counts 10..15,0..5 with DONE only at the 5->0 wrap.
REQ-029 LAP coincident with the 3->4 tick -> LAP_COUNT = 3 in the next cycle.
REQ-030 RST_N pulsed low mid-cycle during RUN with COUNT = 4 -> all outputs 0 before the next CLK edge; no ticks until START.
